// File: rtl/prog_loader.sv
// Byte-wide program loader: takes host bytes over valid/ready and
// shifts them LSB-first into the FSM core while holding it in reset.
module prog_loader #(
  parameter int PROG_BITS      = 96,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       prog_enable,
  output logic       prog_data,
  output logic       prog_shift,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] checksum
);

  localparam int BW = $clog2(PROG_BITS + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PROG_BITS - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT,
    DONE
  } state_e;

  state_e        state_q;
  logic [7:0]    sr_q;
  logic [7:0]    ck_q;
  logic [BW-1:0] bit_cnt_q;
  logic [2:0]    bb_q;
  logic [TW-1:0] to_q;
  logic          err_q;

  logic last_bit;
  logic byte_end;
  logic timeout;

  assign last_bit = (bit_cnt_q == LAST_BIT);
  assign byte_end = (bb_q == 3'd7);
  // The waiting counter only ever reaches TO_MAX while still in WAIT_BYTE.
  assign timeout  = (TIMEOUT_CYCLES > 0) && (to_q == TO_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      ck_q      <= '0;
      bit_cnt_q <= '0;
      bb_q      <= '0;
      to_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q   <= WAIT_BYTE;
            bit_cnt_q <= '0;
            ck_q      <= '0;
            err_q     <= 1'b0;
            to_q      <= '0;
          end
        end
        WAIT_BYTE: begin
          if (abort || timeout) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else if (in_valid) begin
            state_q <= SHIFT;
            sr_q    <= in_data;
            ck_q    <= ck_q + in_data;
            bb_q    <= '0;
            to_q    <= '0;
          end else if (to_q != '1) begin
            to_q <= to_q + 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            sr_q      <= {1'b0, sr_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            bb_q      <= bb_q + 3'd1;
            if (last_bit) begin
              state_q <= DONE;
            end else if (byte_end) begin
              state_q <= WAIT_BYTE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == WAIT_BYTE);
  assign prog_shift  = (state_q == SHIFT);
  assign prog_enable = (state_q == WAIT_BYTE) || (state_q == SHIFT);
  assign prog_data   = prog_shift & sr_q[0];
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign error       = err_q;
  assign checksum    = ck_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two configurations driven from a per-load
// timeline model built from byte gaps, bit counts and abort points.
module tb_prog_loader;

  localparam int P0 = 96;
  localparam int T0 = 255;
  localparam int P1 = 12;
  localparam int T1 = 8;

  typedef struct {
    int         kind;
    int         dv;
    logic       bt;
    logic [7:0] ck;
    logic [7:0] dd;
    logic       er;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start, abort, in_valid;
  logic [7:0] in_data [2];
  logic [1:0] in_ready, prog_enable, prog_data, prog_shift;
  logic [1:0] busy, done, error;
  logic [7:0] checksum [2];

  int tests = 0;
  int fails = 0;

  logic [1:0] chk_en;
  int         ek [2];
  logic [1:0] ebit, eerr;
  logic [7:0] eck [2];
  int         cur_t [2];
  logic [7:0] m_ck [2];
  logic [1:0] m_err;
  int         pin_id [2], pin_at [2], pin_seq [2];

  int           pin_done [2] = '{0, 0};
  int           nshift [2]   = '{0, 0};
  int           done_t [2]   = '{-1, -1};
  logic [127:0] cap [2];

  logic [7:0] qb [$];
  int         qg [$];

  always #5 clk = ~clk;

  prog_loader #(.PROG_BITS(P0), .TIMEOUT_CYCLES(T0)) u_big (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .prog_enable(prog_enable[0]),
    .prog_data(prog_data[0]), .prog_shift(prog_shift[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]),
    .checksum(checksum[0])
  );

  prog_loader #(.PROG_BITS(P1), .TIMEOUT_CYCLES(T1)) u_small (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .prog_enable(prog_enable[1]),
    .prog_data(prog_data[1]), .prog_shift(prog_shift[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]),
    .checksum(checksum[1])
  );

  task automatic cmp(input string nm, input int d,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d t=%0d got %0h want %0h",
               nm, d, cur_t[d], act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (chk_en[d]) begin
        if (cur_t[d] == 0) begin
          nshift[d] = 0;
          cap[d]    = '0;
          done_t[d] = -1;
        end
        cmp("in_ready", d, in_ready[d], ek[d] == 1);
        cmp("prog_enable", d, prog_enable[d], ek[d] == 1 || ek[d] == 2);
        cmp("prog_shift", d, prog_shift[d], ek[d] == 2);
        cmp("busy", d, busy[d], ek[d] != 0);
        cmp("done", d, done[d], ek[d] == 3);
        cmp("error", d, error[d], eerr[d]);
        cmp("checksum", d, checksum[d], eck[d]);
        if (ek[d] == 2) cmp("prog_data", d, prog_data[d], ebit[d]);
        if (prog_shift[d] === 1'b1) begin
          if (nshift[d] < 128) cap[d][nshift[d]] = prog_data[d];
          nshift[d]++;
        end
        if (done[d] === 1'b1) done_t[d] = cur_t[d];
        if (cur_t[d] == pin_at[d] && pin_seq[d] != pin_done[d]) begin
          pin_done[d] = pin_seq[d];
          case (pin_id[d])
            1: begin
              cmp("pin_done_cycle", d, done_t[d], 109);
              cmp("pin_nbits", d, nshift[d], 96);
              cmp("pin_stream", d, cap[d][95:0],
                  96'h0C0B0A090807060504030201);
              cmp("pin_sum", d, checksum[d], 8'h4E);
              cmp("pin_err", d, error[d], 1'b0);
            end
            2: begin
              cmp("pin_done_cycle", d, done_t[d], 15);
              cmp("pin_nbits", d, nshift[d], 12);
              cmp("pin_stream", d, cap[d][11:0], 12'h5FF);
              cmp("pin_sum", d, checksum[d], 8'hA4);
            end
            3: begin
              cmp("pin_no_done", d, done_t[d], -1);
              cmp("pin_to_err", d, error[d], 1'b1);
              cmp("pin_to_busy", d, busy[d], 1'b0);
            end
            4: begin
              cmp("pin_no_done", d, done_t[d], -1);
              cmp("pin_nbits", d, nshift[d], 20);
              cmp("pin_ab_err", d, error[d], 1'b1);
              cmp("pin_ab_pe", d, prog_enable[d], 1'b0);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Timeline: start at t=0, wait cycles per gap, then one accept cycle,
  // then min(8, bits left) shift cycles; a final DONE cycle unless cut.
  task automatic run_load(input int d, input int abort_at,
                          input int rst_at, input bit junk,
                          input int pid);
    int         p, tmo, nb, n, g, o;
    cyc_t       q [$];
    logic [7:0] c, b;
    bit         ended;
    p     = (d == 0) ? P0 : P1;
    tmo   = (d == 0) ? T0 : T1;
    o     = 1 - d;
    nb    = (p + 7) / 8;
    c     = 8'h00;
    ended = 1'b0;
    q.push_back('{0, 2, 1'b0, m_ck[d], 8'h00, m_err[d]});
    for (int i = 0; i < nb; i++) begin
      g = qg[i];
      b = qb[i];
      if (tmo > 0 && g >= tmo) begin
        repeat (tmo + 1) q.push_back('{1, 0, 1'b0, c, 8'h00, 1'b0});
        ended = 1'b1;
        break;
      end
      repeat (g) q.push_back('{1, 0, 1'b0, c, 8'h00, 1'b0});
      q.push_back('{1, 1, 1'b0, c, b, 1'b0});
      c = c + b;
      n = (p - 8 * i < 8) ? p - 8 * i : 8;
      for (int j = 0; j < n; j++) q.push_back('{2, 2, b[j], c, 8'h00, 1'b0});
    end
    if (!ended) q.push_back('{3, 2, 1'b0, c, 8'h00, 1'b0});
    if (abort_at > 0 && abort_at < q.size() &&
        (q[abort_at].kind == 1 || q[abort_at].kind == 2)) begin
      while (q.size() > abort_at + 1) void'(q.pop_back());
      ended = 1'b1;
    end
    c = q[q.size() - 1].ck;
    repeat (3) q.push_back('{0, 2, 1'b0, c, 8'h00, ended});

    pin_id[d] = pid;
    pin_at[d] = q.size() - 1;
    pin_seq[d]++;
    for (int t = 0; t < q.size(); t++) begin
      @(posedge clk);
      #1;
      start[d] = (t == 0) ||
                 (junk && q[t].kind != 0 && $urandom_range(0, 3) == 0);
      abort[d] = (t == abort_at) ||
                 (junk && q[t].kind == 3 && $urandom_range(0, 1) == 1);
      case (q[t].dv)
        0: begin
          in_valid[d] = 1'b0;
          in_data[d]  = 8'($urandom);
        end
        1: begin
          in_valid[d] = 1'b1;
          in_data[d]  = q[t].dd;
        end
        default: begin
          in_valid[d] = 1'($urandom);
          in_data[d]  = 8'($urandom);
        end
      endcase
      start[o]    = 1'b0;
      abort[o]    = 1'($urandom);
      in_valid[o] = 1'($urandom);
      in_data[o]  = 8'($urandom);
      ek[d]    = q[t].kind;
      ebit[d]  = q[t].bt;
      eck[d]   = q[t].ck;
      eerr[d]  = q[t].er;
      cur_t[d] = t;
      if (t == rst_at) begin
        #2;
        rst      = 1'b1;
        start    = '0;
        abort    = '0;
        in_valid = '0;
        for (int k = 0; k < 2; k++) begin
          ek[k]   = 0;
          eck[k]  = 8'h00;
          m_ck[k] = 8'h00;
        end
        eerr  = '0;
        m_err = '0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        return;
      end
    end
    m_ck[d]  = c;
    m_err[d] = ended;
    start    = '0;
    abort    = '0;
    in_valid = '0;
  endtask

  task automatic fill(input int nb, input int gmin, input int gmax);
    qb.delete();
    qg.delete();
    for (int i = 0; i < nb; i++) begin
      qb.push_back(8'($urandom));
      qg.push_back(int'($urandom_range(gmin, gmax)));
    end
  endtask

  initial begin
    rst      = 1'b0;
    start    = '0;
    abort    = '0;
    in_valid = '0;
    chk_en   = '0;
    ebit     = '0;
    eerr     = '0;
    m_err    = '0;
    for (int k = 0; k < 2; k++) begin
      in_data[k] = 8'h00;
      ek[k]      = 0;
      eck[k]     = 8'h00;
      m_ck[k]    = 8'h00;
      cur_t[k]   = -1;
      pin_id[k]  = 0;
      pin_at[k]  = -100;
      pin_seq[k] = 0;
    end
    #1 rst = 1'b1;
    #1 chk_en = 2'b11;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    qb.delete();
    qg.delete();
    for (int i = 0; i < 12; i++) begin
      qb.push_back(8'(i + 1));
      qg.push_back(0);
    end
    run_load(0, -1, -1, 1'b0, 1);

    qb.delete();
    qg.delete();
    qb.push_back(8'hFF);
    qb.push_back(8'hA5);
    qg.push_back(0);
    qg.push_back(0);
    run_load(1, -1, -1, 1'b0, 2);

    fill(12, 20, 20);
    run_load(0, -1, -1, 1'b0, 0);

    fill(2, 0, 0);
    qg[1] = 10;
    run_load(1, -1, -1, 1'b0, 3);

    fill(12, 0, 0);
    run_load(0, 23, -1, 1'b0, 4);

    @(posedge clk);
    #1;
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    abort[0] = 1'b0;
    repeat (2) @(posedge clk);

    fill(12, 0, 2);
    run_load(0, -1, -1, 1'b1, 0);

    fill(12, 0, 1);
    run_load(0, -1, 40, 1'b0, 0);
    fill(12, 0, 1);
    run_load(0, -1, -1, 1'b0, 0);

    for (int r = 0; r < 4; r++) begin
      fill(12, 0, 3);
      run_load(0, ($urandom_range(0, 2) == 0) ?
               int'($urandom_range(1, 80)) : -1, -1, 1'b1, 0);
    end
    for (int r = 0; r < 10; r++) begin
      fill(2, 0, 10);
      run_load(1, ($urandom_range(0, 3) == 0) ?
               int'($urandom_range(1, 20)) : -1, -1, 1'b1, 0);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Byte-wide configuration sequencer for the programmable FSM core's serial instruction/constant memory. It accepts program bytes from a host over a valid/ready handshake and serialises them LSB-first onto prog_data. It holds prog_enable high for the whole load, which keeps the FSM core in reset, then releases the core and reports done, error and a checksum. It sits between the chip pins and the FSM core's prog_enable/prog_data inputs.

Parameters:
PROG_BITS, 96, total bits shifted per load (8 states x 8 instruction bits + 2 x 16 constant bits); must be >= 1.
TIMEOUT_CYCLES, 255, max cycles waiting in WAIT_BYTE before the load aborts with error; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
start  input  1  begin a load; sampled only in IDLE
abort  input  1  cancel a load in progress
in_valid  input  1  host byte valid
in_data  input  8  host program byte
in_ready  output  1  loader accepts byte this cycle
prog_enable  output  1  program mode to the FSM core; holds the core in reset
prog_data  output  1  serial program bit
prog_shift  output  1  prog_data is valid this cycle; the core shifts on prog_enable && prog_shift
busy  output  1  state != IDLE
done  output  1  one-cycle pulse: load completed
error  output  1  sticky: last load aborted or timed out; cleared by an accepted start
checksum  output  8  sum mod 256 of bytes accepted in the current/last load

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; shift register, bit counter, byte-bit counter, timeout counter and checksum cleared.
- States: IDLE, WAIT_BYTE, SHIFT, DONE. All outputs are registered or decoded from state; no combinational path from in_valid to in_ready.
- IDLE: start=1 and abort=0 -> WAIT_BYTE; clear bit_cnt, checksum, error and timeout counter.
- prog_enable=1 in WAIT_BYTE and SHIFT; 0 in IDLE and DONE.
- WAIT_BYTE: in_ready=1. When in_valid=1, the byte is accepted: load the shift register, checksum += in_data (8-bit wrap), go to SHIFT. The timeout counter increments each WAIT_BYTE cycle and resets on each accept.
- SHIFT: prog_shift=1 and prog_data=sr[0] each cycle; shift the register right; bit_cnt++.
  - Leave SHIFT after 8 bits, or when bit_cnt reaches PROG_BITS-1 on this cycle.
  - Then go to DONE if total bits == PROG_BITS, else to WAIT_BYTE.
  - Unused upper bits of the final byte are discarded and never driven.
- Timing: byte accepted at cycle k -> prog_shift high at k+1..k+8 (bit i at k+1+i) -> in_ready at k+9.
  - Back-to-back host: 9 cycles per byte.
  - 96-bit load with an always-valid host: start at cycle 0, done at cycle 109.
- DONE: one cycle. done=1, prog_enable=0 -> IDLE.
- Abort (abort=1 in WAIT_BYTE or SHIFT):
  - Next state IDLE, error=1, prog_enable drops the next cycle, no done pulse.
  - abort has priority over in_valid and over bit completion in the same cycle.
  - abort in IDLE or DONE is ignored.
- Timeout: TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES in WAIT_BYTE -> same as abort.
- start while busy: ignored. start and abort together in IDLE: no start.
- Mid-load reset: immediately IDLE, prog_enable=0, error=0. The partial program in the core is undefined and the host must reload.
- Widths:
  - bit_cnt is $clog2(PROG_BITS+1) bits.
  - timeout counter is $clog2(TIMEOUT_CYCLES+1) bits, saturating.
  - byte-bit counter is 3 bits.

Test Plan:
- Full load, PROG_BITS=96, bytes 0x01..0x0C, always valid -> 96 prog_shift cycles, bit stream LSB-first matching the bytes, done pulse at cycle 109, checksum=0x4E, error=0, prog_enable low from the done cycle.
- PROG_BITS=12, bytes 0xFF, 0xA5 -> 12 shifted bits: eight 1s then 1,0,1,0; in_ready never reasserts after the second byte; done 5 cycles after the second accept.
- Host stalls 20 cycles between bytes with TIMEOUT_CYCLES=255 -> load completes, prog_enable stays high through the gaps. TIMEOUT_CYCLES=8 with a 10-cycle stall -> error=1, busy=0, no done.
- abort asserted on the 4th bit of byte 3 -> next cycle IDLE, prog_enable=0, error=1. A following start clears error and completes normally.
- start pulsed mid-load -> ignored, bit count unaffected. start+abort together in IDLE -> stays IDLE.
- rst asserted asynchronously mid-SHIFT (not on a clock edge) -> outputs 0 immediately. After release, a fresh load produces a correct stream and checksum.
